// File: rtl/soc_data_bus_router.sv
// Data-bus router: decodes master requests against a base/mask map and routes them to
// one of NUM_SLAVES slaves; in-order responses are tracked by a slave-ID FIFO.
module soc_data_bus_router #(
  parameter int unsigned NUM_SLAVES      = 8,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = {
    32'h0101_0000, 32'h0100_3000, 32'h0100_2000, 32'h0100_1000,
    32'h0100_0000, 32'h0010_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = {
    32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_F000, 32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_F000}
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   m_req,
  input  logic                                   m_we,
  input  logic [ADDR_W-1:0]                      m_addr,
  input  logic [DATA_W/8-1:0]                    m_be,
  input  logic [DATA_W-1:0]                      m_wdata,
  output logic                                   m_gnt,
  output logic                                   m_rvalid,
  output logic                                   m_err,
  output logic [DATA_W-1:0]                      m_rdata,
  output logic [NUM_SLAVES-1:0]                  s_req,
  output logic [ADDR_W-1:0]                      s_addr,
  output logic                                   s_we,
  output logic [DATA_W/8-1:0]                    s_be,
  output logic [DATA_W-1:0]                      s_wdata,
  input  logic [NUM_SLAVES-1:0]                  s_gnt,
  input  logic [NUM_SLAVES-1:0]                  s_rvalid,
  input  logic [NUM_SLAVES-1:0]                  s_err,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]      s_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   spurious_rsp
);

  localparam int unsigned ID_W   = $clog2(NUM_SLAVES + 1);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned ERR_ID = NUM_SLAVES;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ID_W-1:0]  id_mem [MAX_OUTSTANDING];
  logic             spurious_q;

  logic [ID_W-1:0]  target;
  logic             target_hit;
  logic [PTR_W-1:0] tail_ptr;
  logic [ID_W-1:0]  tail_id;
  logic [ID_W-1:0]  head_id;
  logic             fifo_empty;
  logic             can_issue;
  logic             push;
  logic             pop;
  logic             spurious_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Address decode: lowest-index hit wins, no hit selects the internal error slave
  always_comb begin
    target     = ID_W'(ERR_ID);
    target_hit = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (!target_hit && ((m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
        target     = ID_W'(i);
        target_hit = 1'b1;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign tail_ptr   = (wr_ptr == '0) ? PTR_W'(MAX_OUTSTANDING - 1) : wr_ptr - PTR_W'(1);
  assign tail_id    = id_mem[tail_ptr];
  assign head_id    = id_mem[rd_ptr];

  // Only one slave may be in flight at a time so responses cannot reorder
  assign can_issue = (count < CNT_W'(MAX_OUTSTANDING)) && (fifo_empty || (target == tail_id));

  // Request routing and grant pass-through
  always_comb begin
    s_req = '0;
    m_gnt = 1'b0;
    if (target_hit) begin
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
        if (target == ID_W'(i)) begin
          s_req[i] = m_req & can_issue;
          m_gnt    = m_req & s_gnt[i] & can_issue;
        end
      end
    end else begin
      m_gnt = m_req & can_issue;
    end
  end

  assign s_addr  = m_addr;
  assign s_we    = m_we;
  assign s_be    = m_be;
  assign s_wdata = m_wdata;

  // Response mux driven by the FIFO head
  always_comb begin
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_rdata  = '0;
    if (!fifo_empty) begin
      if (head_id == ID_W'(ERR_ID)) begin
        m_rvalid = 1'b1;
        m_err    = 1'b1;
      end else begin
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
          if (head_id == ID_W'(i)) begin
            m_rvalid = s_rvalid[i];
            m_err    = s_err[i];
            m_rdata  = s_rdata[i];
          end
        end
      end
    end
  end

  // Any rvalid from a slave that is not at the head is dropped and flagged
  always_comb begin
    spurious_c = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (s_rvalid[i] && (fifo_empty || (head_id != ID_W'(i)))) begin
        spurious_c = 1'b1;
      end
    end
  end

  assign push = m_req & m_gnt;
  assign pop  = m_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      spurious_q <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= target;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (spurious_c) begin
        spurious_q <= 1'b1;
      end
    end
  end

  assign outstanding  = count;
  assign spurious_rsp = spurious_q;

endmodule

// File: doc/soc_data_bus_router.md
# soc_data_bus_router

Parametrised data-bus router for the SoC: connects one OBI-style data-bus master (the core LSU) to `NUM_SLAVES` memory-mapped slaves. It decodes each request address against a parameter-supplied base/mask memory map and routes the request to the selected slave. Responses return in order, tracked by a slave-ID FIFO that allows up to `MAX_OUTSTANDING` transactions in flight. Unmapped addresses are answered by an internal error slave. The block replaces fixed per-slave decode logic and fixed enum-based requested/responding bookkeeping.

## Interface
Parameters:
- `NUM_SLAVES`, 8: number of slave ports, 1..15.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `BE_W = DATA_W/8`.
- `MAX_OUTSTANDING`, 2: ID-FIFO depth, 1..8.
- `SLAVE_BASE`, `[NUM_SLAVES][ADDR_W]`: per-slave base address. Default: BOOT_ROM 0x0000_0000, CODE_RAM 0x0001_0000, DATA_RAM 0x0010_0000, GPIO 0x0100_0000, SPI 0x0100_1000, UART 0x0100_2000, TIMER 0x0100_3000, PMC 0x0101_0000.
- `SLAVE_MASK`, `[NUM_SLAVES][ADDR_W]`: per-slave compare mask. Default: 0xFFFF_F000, 0xFFFF_C000, 0xFFFF_C000, 0xFFFF_F000 ×4, 0xFFFF_0000.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `m_req`, `m_we`, in, 1; `m_addr`, in, ADDR_W; `m_be`, in, BE_W; `m_wdata`, in, DATA_W: master request.
- `m_gnt`, `m_rvalid`, `m_err`, out, 1; `m_rdata`, out, DATA_W: master response.
- `s_req`, out, NUM_SLAVES: one-hot request per slave.
- `s_addr`, `s_we`, `s_be`, `s_wdata`, out: broadcast copies of the master fields.
- `s_gnt`, `s_rvalid`, `s_err`, in, NUM_SLAVES; `s_rdata`, in, NUM_SLAVES×DATA_W: per-slave responses.
- `outstanding`, out, $clog2(MAX_OUTSTANDING+1): current FIFO occupancy.
- `spurious_rsp`, out, 1: sticky flag, set when a slave asserts `s_rvalid` while it is not at the FIFO head.

## Operation
- Decode (combinational): slave i hits when `(m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]`. If several slaves hit, the lowest index wins. If none hits, the target is ERR, with ID = NUM_SLAVES.
- `can_issue = (count < MAX_OUTSTANDING) && (count == 0 || target == tail_id)`. Issue is blocked when the target differs from the last issued ID; this keeps responses in order.
- Mapped target: `s_req[t] = m_req & can_issue`, and `m_gnt = s_gnt[t] & can_issue`. All other `s_req` bits are 0.
- ERR target: `m_gnt = m_req & can_issue`. No `s_req` is asserted.
- Push the target ID into the FIFO on every cycle with `m_req & m_gnt`.
- Response path:
  - Head ID h < NUM_SLAVES: `m_rvalid = s_rvalid[h]`, `m_err = s_err[h]`, `m_rdata = s_rdata[h]`.
  - Head ID h = ERR: `m_rvalid = 1`, `m_err = 1`, `m_rdata = 0`.
  - Empty FIFO: `m_rvalid = 0`, `m_err = 0`, `m_rdata = 0`.
- Pop the FIFO on every cycle with `m_rvalid`.
- Any `s_rvalid[i]` with i ≠ head, or any `s_rvalid` while the FIFO is empty, is ignored and sets `spurious_rsp`. Only reset clears `spurious_rsp`.
- FIFO: circular, pointers wrap modulo MAX_OUTSTANDING. A simultaneous push and pop leaves `count` unchanged. The full check uses the registered `count` only; a pop in the same cycle does not free a slot for issue.

## Timing
- Reset values: `count = 0`, both pointers 0, `spurious_rsp = 0`, `m_gnt = 0`, `m_rvalid = 0`, `m_err = 0`, `m_rdata = 0`, `s_req = 0`.
- Request-to-grant: 0 added cycles; decode and gnt are a combinational pass-through.
- Response: 0 added cycles from `s_rvalid` to `m_rvalid`.
- ERR response: asserted the cycle after the grant, given an empty FIFO. Back-to-back ERR grants produce one response per cycle.
- Reset mid-transaction: the FIFO is flushed. A late `s_rvalid` after reset sets `spurious_rsp`.
- Throughput: one grant per cycle to the same slave while `count < MAX_OUTSTANDING`.

## Test plan
- Read 0x0010_0004: DATA_RAM grants in the same cycle and responds with rdata 0xDEAD_BEEF one cycle later -> `s_req = 8'b0000_0100`; `m_rvalid` high for 1 cycle with `m_rdata = 0xDEAD_BEEF`; `outstanding` goes 0→1→0.
- Read 0x0200_0000 (unmapped) -> `m_gnt` in the same cycle, no `s_req` bit set; the next cycle shows `m_rvalid = 1`, `m_err = 1`, `m_rdata = 0`.
- Two back-to-back reads to GPIO 0x0100_0000 and 0x0100_0004, with GPIO responding 3 cycles after each grant, MAX_OUTSTANDING = 2 -> both granted on consecutive cycles. A third GPIO request stalls (`m_gnt = 0`) until the first response, and is not granted in the cycle of that response; it is granted the following cycle.
- UART write at 0x0100_2000 still outstanding, then a TIMER request at 0x0100_3000 -> TIMER `s_req` stays 0 until the UART `m_rvalid` pops the FIFO; TIMER is granted the next cycle.
- SPI asserts `s_rvalid` while the FIFO is empty -> `m_rvalid` stays 0 and `spurious_rsp` goes to 1 and stays there; pulsing `rst_n` low clears it.
- Overlap check with NUM_SLAVES = 2, SLAVE_BASE = {0x0, 0x0}, SLAVE_MASK = {0xFFFF_0000, 0xFFFF_F000}; read 0x0000_0010 -> slave 0 is selected.
